tdm_demux_8x1: RTL and testbench

Sequential 1-to-8 time-division demultiplexer: the receive-side counterpart of the 8:1 select multiplexer. Accepts a serial slot stream (one data beat per slot, eight slots per frame, slot 0 marked by a frame-sync flag) and distributes the beats onto eight parallel channel outputs. A complete frame updates all eight outputs at the same time. Sits downstream of a TDM link or the mux-based serializer, feeding per-channel logic.

---
 rtl/tdm_pkg.sv | 17 +
 rtl/tdm_slot_ctr.sv | 31 +++
 rtl/tdm_demux_8x1.sv | 158 +++++++++++++++
 tb/tb_tdm_demux_8x1.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tdm_pkg.sv
// Shared constants and types for the 8-slot TDM receive path.
package tdm_pkg;

    // Slots per frame and the width of the slot index.
    localparam int NSLOT = 8;
    localparam int SEL_W = 3;

    // Slot index of the final beat in a frame.
    localparam logic [SEL_W-1:0] LAST_SLOT = 3'd7;

    // HUNT: not frame-aligned yet; RUN: aligned and collecting slots.
    typedef enum logic {
        HUNT = 1'b0,
        RUN  = 1'b1
    } tdm_state_t;

endpackage

// File: rtl/tdm_slot_ctr.sv
// Slot counter for the TDM demux.
// Tracks which slot the next beat belongs to. Clearing has priority over loading,
// and loading has priority over incrementing. Incrementing wraps 7 -> 0.
module tdm_slot_ctr
    import tdm_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             load_one,
    input  logic             inc,
    output logic [SEL_W-1:0] sel,
    output logic             is_last
);

    // Slot index register: the 3-bit increment wraps naturally from 7 back to 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel <= '0;
        end else if (clear) begin
            sel <= '0;
        end else if (load_one) begin
            sel <= {{(SEL_W-1){1'b0}}, 1'b1};
        end else if (inc) begin
            sel <= sel + 1'b1;
        end
    end

    assign is_last = (sel == LAST_SLOT);

endmodule

// File: rtl/tdm_demux_8x1.sv
// 1-to-8 time-division demultiplexer.
// Collects one beat per slot into a shadow register and publishes all eight
// channels together when slot 7 arrives. Partial frames never reach the outputs.
module tdm_demux_8x1
    import tdm_pkg::*;
#(
    parameter int DW = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DW-1:0]    din,
    input  logic             din_valid,
    input  logic             fsync,
    output logic [DW-1:0]    o0,
    output logic [DW-1:0]    o1,
    output logic [DW-1:0]    o2,
    output logic [DW-1:0]    o3,
    output logic [DW-1:0]    o4,
    output logic [DW-1:0]    o5,
    output logic [DW-1:0]    o6,
    output logic [DW-1:0]    o7,
    output logic [SEL_W-1:0] sel,
    output logic             frame_valid,
    output logic             frame_err,
    output logic             locked
);

    tdm_state_t       state;
    tdm_state_t       state_next;

    logic             ctr_clear;
    logic             ctr_load;
    logic             ctr_inc;
    logic             is_last;

    logic             shadow_we;
    logic [SEL_W-1:0] shadow_idx;
    logic             frame_done;
    logic             err_next;

    // Slots 0..6 wait here until slot 7 completes the frame; slot 7 goes straight out.
    logic [DW-1:0]    shadow [NSLOT-1];
    logic [DW-1:0]    outs   [NSLOT];

    tdm_slot_ctr u_slot_ctr (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (ctr_clear),
        .load_one (ctr_load),
        .inc      (ctr_inc),
        .sel      (sel),
        .is_last  (is_last)
    );

    // Decide what the current beat does: align, store, complete, or flag a framing error.
    always_comb begin
        state_next = state;
        ctr_clear  = 1'b0;
        ctr_load   = 1'b0;
        ctr_inc    = 1'b0;
        shadow_we  = 1'b0;
        shadow_idx = sel;
        frame_done = 1'b0;
        err_next   = 1'b0;

        if (din_valid) begin
            case (state)
                HUNT: begin
                    if (fsync) begin
                        shadow_we  = 1'b1;
                        shadow_idx = '0;
                        ctr_load   = 1'b1;
                        state_next = RUN;
                    end
                end
                RUN: begin
                    if (fsync) begin
                        // A sync anywhere but slot 0 abandons the partial frame
                        // and restarts collection with this beat as slot 0.
                        shadow_we  = 1'b1;
                        shadow_idx = '0;
                        ctr_load   = 1'b1;
                        err_next   = (sel != '0);
                    end else if (sel == '0) begin
                        // Slot 0 must carry sync; without it we have lost alignment.
                        err_next   = 1'b1;
                        ctr_clear  = 1'b1;
                        state_next = HUNT;
                    end else if (is_last) begin
                        frame_done = 1'b1;
                        ctr_inc    = 1'b1;
                    end else begin
                        shadow_we  = 1'b1;
                        ctr_inc    = 1'b1;
                    end
                end
                default: begin
                    ctr_clear  = 1'b1;
                    state_next = HUNT;
                end
            endcase
        end
    end

    // FSM state plus the registered status pulses and lock indication.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= HUNT;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            locked      <= 1'b0;
        end else begin
            state       <= state_next;
            frame_valid <= frame_done;
            frame_err   <= err_next;
            locked      <= (state_next == RUN);
        end
    end

    // Shadow storage for slots 0..6 of the frame under construction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NSLOT - 1; i++) begin
                shadow[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NSLOT - 1; i++) begin
                if (shadow_we && (shadow_idx == i[SEL_W-1:0])) begin
                    shadow[i] <= din;
                end
            end
        end
    end

    // Channel outputs: all eight load together only when a frame completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NSLOT; i++) begin
                outs[i] <= '0;
            end
        end else if (frame_done) begin
            for (int i = 0; i < NSLOT - 1; i++) begin
                outs[i] <= shadow[i];
            end
            outs[NSLOT-1] <= din;
        end
    end

    assign o0 = outs[0];
    assign o1 = outs[1];
    assign o2 = outs[2];
    assign o3 = outs[3];
    assign o4 = outs[4];
    assign o5 = outs[5];
    assign o6 = outs[6];
    assign o7 = outs[7];

endmodule

// File: tb/tb_tdm_demux_8x1.sv
// Testbench for tdm_demux_8x1: directed framing scenarios plus randomized traffic,
// checked by a scoreboard fed from a slot-level reference model.
module tb_tdm_demux_8x1;

    localparam int DW = 8;

    typedef logic [7:0][DW-1:0] frame_t;

    typedef struct packed {
        logic       fv;
        logic       fe;
        logic       lk;
        logic [2:0] sel;
        frame_t     outs;
    } status_t;

    logic          clk;
    logic          rst_n;
    logic [DW-1:0] din;
    logic          din_valid;
    logic          fsync;
    logic [DW-1:0] o0, o1, o2, o3, o4, o5, o6, o7;
    logic [2:0]    sel;
    logic          frame_valid;
    logic          frame_err;
    logic          locked;

    frame_t        dutOuts;

    int            tests;
    int            failures;

    status_t       statusQ [$];
    frame_t        frameQ  [$];

    logic          mAligned;
    int            mSlot;
    frame_t        mBuf;
    frame_t        mOuts;

    tdm_demux_8x1 #(.DW(DW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .din         (din),
        .din_valid   (din_valid),
        .fsync       (fsync),
        .o0          (o0),
        .o1          (o1),
        .o2          (o2),
        .o3          (o3),
        .o4          (o4),
        .o5          (o5),
        .o6          (o6),
        .o7          (o7),
        .sel         (sel),
        .frame_valid (frame_valid),
        .frame_err   (frame_err),
        .locked      (locked)
    );

    assign dutOuts = {o7, o6, o5, o4, o3, o2, o1, o0};

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic status_t modelStatus(input logic fv, input logic fe);
        status_t st;
        st.fv   = fv;
        st.fe   = fe;
        st.lk   = mAligned;
        st.sel  = mAligned ? mSlot[2:0] : 3'd0;
        st.outs = mOuts;
        return st;
    endfunction

    // Drive one cycle of input, then advance the slot-level model by that cycle's beat.
    task automatic applyStimulus(input logic v, input logic fs, input logic [DW-1:0] d);
        logic fv;
        logic fe;
        din_valid = v;
        fsync     = fs;
        din       = d;
        @(posedge clk);
        #1;
        fv = 1'b0;
        fe = 1'b0;
        if (v) begin
            if (!mAligned) begin
                if (fs) begin
                    mBuf[0]  = d;
                    mSlot    = 1;
                    mAligned = 1'b1;
                end
            end else if (fs) begin
                fe      = (mSlot != 0);
                mBuf[0] = d;
                mSlot   = 1;
            end else if (mSlot == 0) begin
                fe       = 1'b1;
                mAligned = 1'b0;
            end else begin
                mBuf[mSlot] = d;
                if (mSlot == 7) begin
                    mOuts = mBuf;
                    fv    = 1'b1;
                    frameQ.push_back(mBuf);
                    mSlot = 0;
                end else begin
                    mSlot = mSlot + 1;
                end
            end
        end
        statusQ.push_back(modelStatus(fv, fe));
    endtask

    // Assert reset asynchronously, confirm the outputs clear immediately, then release.
    task automatic doReset();
        din_valid = 1'b0;
        fsync     = 1'b0;
        din       = '0;
        rst_n     = 1'b0;
        #1;
        checkOutput("async_reset_outs", 64'(dutOuts), 64'h0);
        checkOutput("async_reset_status", {58'h0, sel, frame_valid, frame_err, locked}, 64'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n    = 1'b1;
        mAligned = 1'b0;
        mSlot    = 0;
        mBuf     = '0;
        mOuts    = '0;
        statusQ.delete();
        statusQ.push_back(modelStatus(1'b0, 1'b0));
    endtask

    task automatic sendFrame(input frame_t f);
        applyStimulus(1'b1, 1'b1, f[0]);
        for (int i = 1; i < 8; i++) begin
            applyStimulus(1'b1, 1'b0, f[i]);
        end
    endtask

    // Monitor: each cycle pop the expected status; on a frame_valid pulse also pop the expected frame.
    always @(negedge clk) begin
        status_t st;
        if (rst_n === 1'b1) begin
            if (statusQ.size() == 0) begin
                tests++;
                failures++;
                $display("[TB] FAIL status_queue: got empty expected an entry");
            end else begin
                st = statusQ.pop_front();
                checkOutput("frame_valid", 64'(frame_valid), 64'(st.fv));
                checkOutput("frame_err", 64'(frame_err), 64'(st.fe));
                checkOutput("locked", 64'(locked), 64'(st.lk));
                checkOutput("sel", 64'(sel), 64'(st.sel));
                checkOutput("outputs", 64'(dutOuts), 64'(st.outs));
            end
            if (frame_valid === 1'b1) begin
                if (frameQ.size() == 0) begin
                    tests++;
                    failures++;
                    $display("[TB] FAIL frame_data: got unexpected frame %0h expected none", dutOuts);
                end else begin
                    checkOutput("frame_data", 64'(dutOuts), 64'(frameQ.pop_front()));
                end
            end
        end
    end

    initial begin
        frame_t f;
        tests     = 0;
        failures  = 0;
        rst_n     = 1'b1;
        din       = '0;
        din_valid = 1'b0;
        fsync     = 1'b0;
        mAligned  = 1'b0;
        mSlot     = 0;
        mBuf      = '0;
        mOuts     = '0;
        #3;
        doReset();

        // Single frame 1,0,1,1,0,0,1,0 followed by an idle cycle.
        f = {8'd0, 8'd1, 8'd0, 8'd0, 8'd1, 8'd1, 8'd0, 8'd1};
        sendFrame(f);
        applyStimulus(1'b0, 1'b0, 8'h00);

        // Two back-to-back frames, the second all ones.
        f = {8'h5a, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};
        sendFrame(f);
        sendFrame({8{8'hff}});
        applyStimulus(1'b0, 1'b0, 8'h00);

        // Beats without fsync after reset are discarded; the first fsync aligns.
        doReset();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b0, 8'($urandom));
        end
        for (int i = 0; i < 8; i++) f[i] = 8'($urandom);
        sendFrame(f);

        // Early sync on slot 4 restarts the frame with that beat as slot 0.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, (i == 0), 8'(8'h10 + i));
        end
        applyStimulus(1'b1, 1'b1, 8'hc0);
        for (int i = 1; i < 8; i++) begin
            applyStimulus(1'b1, 1'b0, 8'(8'hc0 + i));
        end

        // Missing fsync on slot 0 while locked drops back to HUNT.
        applyStimulus(1'b1, 1'b0, 8'hee);
        applyStimulus(1'b0, 1'b0, 8'h00);

        // Frame delivered with idle gaps between beats.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, (i == 0), 8'(8'ha0 + i));
            repeat ($urandom_range(0, 3)) applyStimulus(1'b0, 1'b1, 8'($urandom));
        end

        // Randomized traffic with occasional framing faults.
        for (int n = 0; n < 600; n++) begin
            logic v;
            logic fs;
            v = ($urandom_range(0, 3) != 0);
            if (mAligned && mSlot != 0) fs = ($urandom_range(0, 29) == 0);
            else                        fs = ($urandom_range(0, 9) != 0);
            applyStimulus(v, fs, 8'($urandom));
        end
        applyStimulus(1'b0, 1'b0, 8'h00);

        // Asynchronous reset in the middle of a frame.
        applyStimulus(1'b1, 1'b1, 8'h31);
        applyStimulus(1'b1, 1'b0, 8'h32);
        applyStimulus(1'b1, 1'b0, 8'h33);
        doReset();
        for (int i = 0; i < 8; i++) f[i] = 8'($urandom);
        sendFrame(f);
        repeat (3) applyStimulus(1'b0, 1'b0, 8'h00);

        @(negedge clk);
        #1;
        checkOutput("frame_queue_empty", 64'(frameQ.size()), 64'h0);
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
